// File: rtl/mem_dir_pkg.sv
// Shared encodings, FSM state enum and directory-entry layout for mem_dir_ctrl.
package mem_dir_pkg;

    localparam int MAX_CORE = 16;
    localparam int OWN_W    = 4;

    typedef enum logic [1:0] {
        RQ_RD_SH = 2'b00,
        RQ_RD_EX = 2'b01,
        RQ_WB    = 2'b10,
        RQ_RSVD  = 2'b11
    } req_type_e;

    typedef enum logic [1:0] {
        RP_DATA_SH = 2'b00,
        RP_DATA_EX = 2'b01,
        RP_WB_ACK  = 2'b10,
        RP_NACK    = 2'b11
    } rep_type_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        EVAL,
        INV,
        REP,
        UPD
    } state_e;

    // Entry is sized for the largest supported core count; only NCORE sharer bits are ever set.
    typedef struct packed {
        logic                mod;
        logic [OWN_W-1:0]    owner;
        logic [MAX_CORE-1:0] sharers;
    } dir_entry_t;

    function automatic logic [MAX_CORE-1:0] core_bit(input logic [OWN_W-1:0] id);
        return MAX_CORE'(1) << id;
    endfunction

endpackage

// File: rtl/mem_dir_ram.sv
// Directory and line-data storage: synchronous read, registered outputs, directory cleared on reset.
module mem_dir_ram
    import mem_dir_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int LINE_W = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output dir_entry_t               rd_entry,
    output logic [LINE_W-1:0]        rd_data,
    input  logic                     dir_we,
    input  logic                     data_we,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  dir_entry_t               wr_entry,
    input  logic [LINE_W-1:0]        wr_data
);

    dir_entry_t        dir_mem  [DEPTH];
    logic [LINE_W-1:0] data_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dir_mem[i] <= '0;
            end
            rd_entry <= '0;
        end else begin
            if (dir_we) begin
                dir_mem[wr_idx] <= wr_entry;
            end
            if (rd_en) begin
                rd_entry <= dir_mem[rd_idx];
            end
        end
    end

    // Line data has no reset so it can map onto a plain block RAM.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= data_mem[rd_idx];
        end
    end

endmodule

// File: rtl/mem_dir_ctrl.sv
// Single-outstanding directory controller with round-robin request arbitration.
// Optional invalidation path enabled by defining MEM_DIR_INV_EN.
module mem_dir_ctrl
    import mem_dir_pkg::*;
#(
    parameter int NCORE  = 4,
    parameter int NSRC   = 3,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NSRC-1:0]                  req_valid,
    output logic [NSRC-1:0]                  req_ready,
    input  logic [2*NSRC-1:0]                req_type,
    input  logic [NSRC*$clog2(NCORE)-1:0]    req_id,
    input  logic [NSRC*ADDR_W-1:0]           req_addr,
    input  logic [NSRC*LINE_W-1:0]           req_data,
    output logic                             rep_valid,
    input  logic                             rep_ready,
    output logic [1:0]                       rep_type,
    output logic [$clog2(NCORE)-1:0]         rep_id,
    output logic [ADDR_W-1:0]                rep_addr,
    output logic [LINE_W-1:0]                rep_data,
    output logic                             inv_valid,
    input  logic                             inv_ready,
    output logic [NCORE-1:0]                 inv_mask,
    output logic [ADDR_W-1:0]                inv_addr,
    output logic                             busy
);

    localparam int IDW = $clog2(NCORE);
    localparam int SW  = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int OFF = $clog2(LINE_W / 8);

    state_e              state, state_nx;
    logic [SW-1:0]       ptr;
    logic                gnt_found;
    logic [SW-1:0]       gnt_idx;

    logic [1:0]          src_type [NSRC];
    logic [IDW-1:0]      src_id   [NSRC];
    logic [ADDR_W-1:0]   src_addr [NSRC];
    logic [LINE_W-1:0]   src_data [NSRC];

    req_type_e           type_q;
    logic [IDW-1:0]      id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   data_q;

    rep_type_e           rep_type_q;
    logic [LINE_W-1:0]   rep_data_q;
    dir_entry_t          new_entry_q;
    logic                dir_we_q;
    logic                data_we_q;

    dir_entry_t          rd_entry;
    logic [LINE_W-1:0]   rd_data;
    logic [AW-1:0]       line_idx;

    rep_type_e           ev_rep;
    logic [LINE_W-1:0]   ev_data;
    logic [MAX_CORE-1:0] ev_mask;
    logic [MAX_CORE-1:0] req_bit;
    dir_entry_t          ev_entry;
    logic                ev_dir_we;
    logic                ev_data_we;

    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            src_type[s] = req_type[2*s +: 2];
            src_id[s]   = req_id[IDW*s +: IDW];
            src_addr[s] = req_addr[ADDR_W*s +: ADDR_W];
            src_data[s] = req_data[LINE_W*s +: LINE_W];
        end
    end

    // Round-robin search starting at ptr; the first valid source wins.
    always_comb begin : arb
        int j;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = 0; k < NSRC; k++) begin
            j = int'(ptr) + k;
            if (j >= NSRC) begin
                j = j - NSRC;
            end
            if (!gnt_found && req_valid[SW'(j)]) begin
                gnt_found = 1'b1;
                gnt_idx   = SW'(j);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && rst && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign line_idx = addr_q[OFF +: AW];

    always_comb begin
        req_bit    = core_bit(OWN_W'(id_q));
        ev_rep     = RP_NACK;
        ev_data    = '0;
        ev_mask    = '0;
        ev_entry   = rd_entry;
        ev_dir_we  = 1'b0;
        ev_data_we = 1'b0;
        case (type_q)
            RQ_RD_SH: begin
                if (!rd_entry.mod) begin
                    ev_rep           = RP_DATA_SH;
                    ev_data          = rd_data;
                    ev_entry.sharers = rd_entry.sharers | req_bit;
                    ev_dir_we        = 1'b1;
                end else begin
`ifdef MEM_DIR_INV_EN
                    ev_rep           = RP_DATA_SH;
                    ev_data          = rd_data;
                    ev_mask          = core_bit(rd_entry.owner);
                    ev_entry.mod     = 1'b0;
                    ev_entry.sharers = core_bit(rd_entry.owner) | req_bit;
                    ev_dir_we        = 1'b1;
`endif
                end
            end
            RQ_RD_EX: begin
                ev_rep  = RP_DATA_EX;
                ev_data = rd_data;
`ifdef MEM_DIR_INV_EN
                ev_mask = (rd_entry.mod ? core_bit(rd_entry.owner) : rd_entry.sharers) & ~req_bit;
`endif
                ev_entry.mod     = 1'b1;
                ev_entry.owner   = OWN_W'(id_q);
                ev_entry.sharers = req_bit;
                ev_dir_we        = 1'b1;
            end
            RQ_WB: begin
                ev_rep     = RP_WB_ACK;
                ev_entry   = '0;
                ev_dir_we  = 1'b1;
                ev_data_we = 1'b1;
            end
            default: begin
                ev_rep = RP_NACK;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_found) state_nx = RD;
            RD:      state_nx = EVAL;
            EVAL:    state_nx = (|ev_mask) ? INV : REP;
            INV:     if (inv_ready) state_nx = REP;
            REP:     if (rep_ready) state_nx = UPD;
            UPD:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            type_q      <= RQ_RD_SH;
            id_q        <= '0;
            addr_q      <= '0;
            rep_type_q  <= RP_DATA_SH;
            rep_data_q  <= '0;
            new_entry_q <= '0;
            dir_we_q    <= 1'b0;
            data_we_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && gnt_found) begin
                type_q <= req_type_e'(src_type[gnt_idx]);
                id_q   <= src_id[gnt_idx];
                addr_q <= src_addr[gnt_idx];
                ptr    <= (int'(gnt_idx) == NSRC - 1) ? '0 : gnt_idx + 1'b1;
            end
            // Decision captured here so reply/invalidate fields stay stable while stalled.
            if (state == EVAL) begin
                rep_type_q  <= ev_rep;
                rep_data_q  <= ev_data;
                new_entry_q <= ev_entry;
                dir_we_q    <= ev_dir_we;
                data_we_q   <= ev_data_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && gnt_found) begin
            data_q <= src_data[gnt_idx];
        end
    end

`ifdef MEM_DIR_INV_EN
    logic [NCORE-1:0] inv_mask_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inv_mask_q <= '0;
        end else if (state == EVAL) begin
            inv_mask_q <= ev_mask[NCORE-1:0];
        end
    end

    assign inv_valid = (state == INV);
    assign inv_mask  = inv_mask_q;
    assign inv_addr  = addr_q;
`else
    assign inv_valid = 1'b0;
    assign inv_mask  = '0;
    assign inv_addr  = '0;
`endif

    assign rep_valid = (state == REP);
    assign rep_type  = rep_type_q;
    assign rep_id    = id_q;
    assign rep_addr  = addr_q;
    assign rep_data  = rep_data_q;
    assign busy      = (state != IDLE);

    mem_dir_ram #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (state == RD),
        .rd_idx   (line_idx),
        .rd_entry (rd_entry),
        .rd_data  (rd_data),
        .dir_we   (state == UPD && dir_we_q),
        .data_we  (state == UPD && data_we_q),
        .wr_idx   (line_idx),
        .wr_entry (new_entry_q),
        .wr_data  (data_q)
    );

endmodule

// File: tb/tb_mem_dir_ctrl.sv
// Directed, table-driven bench for mem_dir_ctrl; expectations follow MEM_DIR_INV_EN when defined.
module tb_mem_dir_ctrl;

    localparam int NCORE  = 4;
    localparam int NSRC   = 3;
    localparam int LINE_W = 128;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int IDW    = 2;

    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] D5A = {16{8'h5A}};

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic [NSRC-1:0]             req_valid;
    logic [NSRC-1:0]             req_ready;
    logic [2*NSRC-1:0]           req_type;
    logic [NSRC*IDW-1:0]         req_id;
    logic [NSRC*ADDR_W-1:0]      req_addr;
    logic [NSRC*LINE_W-1:0]      req_data;
    logic                        rep_valid;
    logic                        rep_ready;
    logic [1:0]                  rep_type;
    logic [IDW-1:0]              rep_id;
    logic [ADDR_W-1:0]           rep_addr;
    logic [LINE_W-1:0]           rep_data;
    logic                        inv_valid;
    logic                        inv_ready;
    logic [NCORE-1:0]            inv_mask;
    logic [ADDR_W-1:0]           inv_addr;
    logic                        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_dir_ctrl #(
        .NCORE(NCORE), .NSRC(NSRC), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_id(req_id), .req_addr(req_addr), .req_data(req_data),
        .rep_valid(rep_valid), .rep_ready(rep_ready), .rep_type(rep_type),
        .rep_id(rep_id), .rep_addr(rep_addr), .rep_data(rep_data),
        .inv_valid(inv_valid), .inv_ready(inv_ready), .inv_mask(inv_mask),
        .inv_addr(inv_addr), .busy(busy)
    );

    typedef struct {
        int           src;
        logic [1:0]   typ;
        int           id;
        logic [31:0]  addr;
        logic [127:0] data;
        logic [1:0]   e_type;
        logic         e_inv;
        logic [3:0]   e_mask;
        logic         e_chkd;
        logic [127:0] e_data;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_src(input int s, input logic [1:0] t, input int id,
                           input logic [31:0] a, input logic [127:0] d);
        req_type[2*s +: 2]           = t;
        req_id[IDW*s +: IDW]         = IDW'(id);
        req_addr[ADDR_W*s +: ADDR_W] = a;
        req_data[LINE_W*s +: LINE_W] = d;
        req_valid[s]                 = 1'b1;
    endtask

    task automatic wait_grant(input int s, output logic ok);
        int cyc;
        cyc = 0;
        #1;
        while (!req_ready[s] && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        ok = req_ready[s];
        @(negedge clk);
        req_valid[s] = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic txn(input int s, input logic [1:0] t, input int id, input logic [31:0] a,
                       input logic [127:0] d,
                       output logic got, output logic [1:0] rt, output logic [IDW-1:0] rid,
                       output logic [31:0] ra, output logic [127:0] rd,
                       output logic iseen, output logic [3:0] im, output logic excl);
        int   cyc;
        logic gok;
        got = 1'b0; rt = '0; rid = '0; ra = '0; rd = '0; iseen = 1'b0; im = '0; excl = 1'b1;
        @(negedge clk);
        set_src(s, t, id, a, d);
        wait_grant(s, gok);
        cyc = 0;
        while (gok && !got && cyc < 30) begin
            if (rep_valid && inv_valid) excl = 1'b0;
            if (inv_valid) begin
                iseen = 1'b1;
                im    = inv_mask;
            end
            if (rep_valid) begin
                got = 1'b1;
                rt  = rep_type;
                rid = rep_id;
                ra  = rep_addr;
                rd  = rep_data;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        wait_idle();
    endtask

    vec_t         tbl [11];
    logic         got, iseen, excl, gok, stable;
    logic [1:0]   rt;
    logic [IDW-1:0] rid;
    logic [31:0]  ra;
    logic [127:0] rd;
    logic [3:0]   im;
    int           gcount, cyc;
    int           order [4];

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        //            src typ    id addr    data  e_type e_inv e_mask e_chkd e_data
        tbl[0]  = '{0, 2'b00, 2, 32'h40,  '0,  2'b00, 1'b0, 4'h0, 1'b0, '0};
`ifdef MEM_DIR_INV_EN
        tbl[1]  = '{1, 2'b01, 1, 32'h40,  '0,  2'b01, 1'b1, 4'b0100, 1'b0, '0};
`else
        tbl[1]  = '{1, 2'b01, 1, 32'h40,  '0,  2'b01, 1'b0, 4'h0, 1'b0, '0};
`endif
        tbl[2]  = '{2, 2'b00, 0, 32'h80,  '0,  2'b00, 1'b0, 4'h0, 1'b0, '0};
        tbl[3]  = '{0, 2'b00, 1, 32'h80,  '0,  2'b00, 1'b0, 4'h0, 1'b0, '0};
`ifdef MEM_DIR_INV_EN
        tbl[4]  = '{1, 2'b01, 3, 32'h80,  '0,  2'b01, 1'b1, 4'b0011, 1'b0, '0};
        tbl[5]  = '{2, 2'b00, 0, 32'h80,  '0,  2'b00, 1'b1, 4'b1000, 1'b0, '0};
`else
        tbl[4]  = '{1, 2'b01, 3, 32'h80,  '0,  2'b01, 1'b0, 4'h0, 1'b0, '0};
        tbl[5]  = '{2, 2'b00, 0, 32'h80,  '0,  2'b11, 1'b0, 4'h0, 1'b1, '0};
`endif
        tbl[6]  = '{0, 2'b10, 3, 32'h80,  DA5, 2'b10, 1'b0, 4'h0, 1'b1, '0};
        tbl[7]  = '{1, 2'b00, 0, 32'h80,  '0,  2'b00, 1'b0, 4'h0, 1'b1, DA5};
        tbl[8]  = '{2, 2'b11, 1, 32'h80,  D5A, 2'b11, 1'b0, 4'h0, 1'b1, '0};
`ifdef MEM_DIR_INV_EN
        tbl[9]  = '{0, 2'b01, 2, 32'h80,  '0,  2'b01, 1'b1, 4'b0001, 1'b1, DA5};
        tbl[10] = '{1, 2'b00, 1, 32'h80,  '0,  2'b00, 1'b1, 4'b0100, 1'b1, DA5};
`else
        tbl[9]  = '{0, 2'b01, 2, 32'h80,  '0,  2'b01, 1'b0, 4'h0, 1'b1, DA5};
        tbl[10] = '{1, 2'b00, 1, 32'h80,  '0,  2'b11, 1'b0, 4'h0, 1'b1, '0};
`endif

        // Reset state with every source requesting.
        req_valid = '1; req_type = '0; req_id = '0; req_addr = '0; req_data = '0;
        rep_ready = 1'b1; inv_ready = 1'b1;
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_rep_valid", rep_valid, 0);
        check("rst_inv_valid", inv_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rep_addr", rep_addr, 0);
        check("rst_rep_data", rep_data, 0);
        check("rst_inv_mask", inv_mask, 0);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            txn(tbl[i].src, tbl[i].typ, tbl[i].id, tbl[i].addr, tbl[i].data,
                got, rt, rid, ra, rd, iseen, im, excl);
            check($sformatf("v%0d_got_rep", i), got, 1);
            check($sformatf("v%0d_rep_type", i), rt, tbl[i].e_type);
            check($sformatf("v%0d_rep_id", i), rid, tbl[i].id);
            check($sformatf("v%0d_rep_addr", i), ra, tbl[i].addr);
            check($sformatf("v%0d_inv_seen", i), iseen, tbl[i].e_inv);
            if (tbl[i].e_inv) check($sformatf("v%0d_inv_mask", i), im, tbl[i].e_mask);
            if (tbl[i].e_chkd) check($sformatf("v%0d_rep_data", i), rd, tbl[i].e_data);
            check($sformatf("v%0d_rep_inv_excl", i), excl, 1);
        end

        // Round robin: all sources held valid from a fresh reset.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        set_src(0, 2'b00, 0, 32'h200, '0);
        set_src(1, 2'b00, 1, 32'h200, '0);
        set_src(2, 2'b00, 2, 32'h200, '0);
        gcount = 0;
        cyc = 0;
        while (gcount < 4 && cyc < 60) begin
            #1;
            if (|req_ready) begin
                check($sformatf("rr_onehot_%0d", gcount), $onehot(req_ready), 1);
                order[gcount] = req_ready[0] ? 0 : (req_ready[1] ? 1 : 2);
                gcount++;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        check("rr_grant_count", gcount, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < gcount) check($sformatf("rr_order_%0d", k), order[k], k % 3);
        end
        wait_idle();

        // Reply stall: fields stable, busy held, no new grant.
        @(negedge clk);
        rep_ready = 1'b0;
        set_src(0, 2'b00, 1, 32'h300, '0);
        wait_grant(0, gok);
        check("stall_grant", gok, 1);
        set_src(1, 2'b00, 2, 32'h300, '0);
        cyc = 0;
        while (!rep_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("stall_rep_valid", rep_valid, 1);
        rt = rep_type; ra = rep_addr;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!rep_valid || rep_type !== rt || rep_addr !== ra || rep_id !== 2'd1 ||
                !busy || req_ready !== '0 || inv_valid) stable = 1'b0;
        end
        check("stall_stable", stable, 1);
        check("stall_rep_type", rt, 2'b00);
        check("stall_rep_addr", ra, 32'h300);
        req_valid = '0;
        rep_ready = 1'b1;
        wait_idle();

        // Reset during a stalled invalidate (or reply) must abandon it without writes.
        txn(2, 2'b10, 1, 32'h100, D5A, got, rt, rid, ra, rd, iseen, im, excl);
        check("mr_wb_type", rt, 2'b10);
        txn(0, 2'b00, 0, 32'h100, '0, got, rt, rid, ra, rd, iseen, im, excl);
        check("mr_rdsh_data", rd, D5A);
        @(negedge clk);
        inv_ready = 1'b0;
        rep_ready = 1'b0;
        set_src(1, 2'b01, 2, 32'h100, '0);
        wait_grant(1, gok);
        cyc = 0;
        while (!inv_valid && !rep_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
`ifdef MEM_DIR_INV_EN
        check("mr_inv_valid", inv_valid, 1);
        check("mr_inv_mask", inv_mask, 4'b0001);
        check("mr_inv_addr", inv_addr, 32'h100);
`else
        check("mr_rep_valid", rep_valid, 1);
        check("mr_no_inv", inv_valid, 0);
`endif
        rst = 1'b0;
        #1;
        check("mr_busy_after_rst", busy, 0);
        check("mr_inv_after_rst", inv_valid, 0);
        check("mr_rep_after_rst", rep_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        inv_ready = 1'b1;
        rep_ready = 1'b1;
        txn(2, 2'b00, 1, 32'h100, '0, got, rt, rid, ra, rd, iseen, im, excl);
        check("mr_after_type", rt, 2'b00);
        check("mr_after_inv", iseen, 0);
        check("mr_after_data", rd, D5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dir_ctrl.md
MEM_DIR_CTRL -- requirements
Module: mem_dir_ctrl

Interface
REQ-001 SHALL have parameter NCORE, default 4, number of cores tracked in the sharer vector (2..16).
REQ-002 SHALL have parameter NSRC, default 3, number of request sources (local d, local i, infifo).
REQ-003 SHALL have parameter LINE_W, default 128, cache-line width in bits.
REQ-004 SHALL have parameter ADDR_W, default 32, address width.
REQ-005 SHALL have parameter DEPTH, default 256, lines held (power of two).
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: req_valid in NSRC; req_ready out NSRC; req_type in 2*NSRC (00 RD_SH, 01 RD_EX, 10 WB, 11 reserved); req_id in NSRC*$clog2(NCORE) requester core; req_addr in NSRC*ADDR_W; req_data in NSRC*LINE_W.
REQ-008 SHALL have ports: rep_valid out 1; rep_ready in 1; rep_type out 2 (00 DATA_SH, 01 DATA_EX, 10 WB_ACK, 11 NACK); rep_id out $clog2(NCORE); rep_addr out ADDR_W; rep_data out LINE_W.
REQ-009 SHALL have ports: inv_valid out 1; inv_ready in 1; inv_mask out NCORE one bit per core to invalidate; inv_addr out ADDR_W; busy out 1.

Function
REQ-010 Line index SHALL be req_addr[$clog2(LINE_W/8) +: $clog2(DEPTH)]; upper bits ignored.
REQ-011 Directory entry per line SHALL be {mod bit, owner id, NCORE-bit sharer mask}, with data held in a DEPTH x LINE_W synchronous RAM (1-cycle read latency).
REQ-012 FSM states SHALL be IDLE, RD, EVAL, INV, REP, UPD.
REQ-013 In IDLE, round-robin arbitration over valid sources SHALL grant one; req_ready of that source is high for exactly that cycle and the request is latched; pointer advances past the granted source.
REQ-014 RD SHALL issue the directory/data read; EVAL SHALL decide action on the returned entry one cycle later.
REQ-015 RD_SH: if mod clear, go REP with DATA_SH, set requester sharer bit; if mod set, go INV with inv_mask = owner bit only, then REP, clear mod, sharers = owner|requester.
REQ-016 RD_EX: inv_mask = sharers with requester bit cleared (or owner bit if mod); INV skipped when mask is zero; reply DATA_EX; new entry mod=1, owner=requester, sharers=requester only.
REQ-017 WB: RAM data written with latched req_data, entry cleared to mod=0, sharers=0; reply WB_ACK with rep_data = 0.
REQ-018 Reserved type SHALL reply NACK with directory and data unchanged.
REQ-019 INV SHALL hold inv_valid, inv_mask, inv_addr stable until inv_ready sampled high, then proceed to REP.
REQ-020 REP SHALL hold rep_* stable until rep_ready sampled high, then go UPD; rep_id = latched req_id.
REQ-021 UPD SHALL write the new entry (and data for WB) in one cycle and return to IDLE; minimum request-to-IDLE latency 5 cycles with ready asserted.
REQ-022 busy SHALL be high in every state except IDLE; no grant while busy (single outstanding request).
REQ-023 rep_valid and inv_valid SHALL never be high in the same cycle.

Reset
REQ-024 On rst low, FSM SHALL go IDLE asynchronously; req_ready, rep_valid, inv_valid, busy = 0; rep_*/inv_* data fields = 0; arbiter pointer = source 0.
REQ-025 On reset, all directory entries SHALL be cleared (mod=0, sharers=0); data RAM content is unspecified. Reset mid-transaction SHALL abandon the transaction with no RAM write.

Configuration
REQ-026 Macro MEM_DIR_INV_EN defined: behaviour per REQ-015/016/019.
REQ-027 MEM_DIR_INV_EN undefined: INV state never entered, inv_valid tied 0, inv_mask 0; RD_EX replies DATA_EX with entry updated as REQ-016; RD_SH on a modified line replies NACK.

Structure
REQ-028 Shared package mem_dir_pkg SHALL hold req/rep type encodings, FSM state enum and the directory-entry struct typedef.
REQ-029 Sub-module mem_dir_ram SHALL hold directory and data arrays (sync read, write enable, directory clear on reset).

Verification
REQ-030 Reset, RD_SH from core 2 on addr 0x40 -> DATA_SH to id 2, no inv, sharers=0b0100.
REQ-031 Cores 0,1 RD_SH 0x80 then core 3 RD_EX 0x80 -> inv_mask 0b0011, then DATA_EX to id 3, mod=1 owner=3.
REQ-032 Core 3 WB 0x80 data 0xA5.. then core 0 RD_SH 0x80 -> WB_ACK, then DATA_SH with data 0xA5...
REQ-033 All three sources valid together, repeated -> grants 0,1,2,0 order; each source ready pulses once per grant.
REQ-034 rep_ready held low 10 cycles -> rep_* stable, busy high, no new grant; reset asserted mid-INV -> IDLE, entry unchanged.
REQ-035 Reserved type 11 -> NACK, directory and data unchanged; build without MEM_DIR_INV_EN -> inv_valid never asserted.
